// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM-stage data-memory access unit. Takes address, store data
//               and control from EX/MEM, runs a req/ack transaction to data
//               memory, steers byte/half lanes, extends load results, flags
//               misaligned accesses and aborts transactions that never ack.
//
// Ports       : Clk, Rst                 clock / synchronous active-high reset
//               ValidIn, MemReadIn,
//               MemWriteIn, MemSizeIn,
//               MemSignedIn, AddrIn,
//               WriteDataIn              operation from EX/MEM
//               MemReq, MemWe, MemAddr,
//               MemBe, MemWData          request side of the memory bus
//               MemRData, MemAck         response side of the memory bus
//               ReadDataOut              extended load result to MEM/WB
//               Stall                    hold EX/MEM and upstream this cycle
//               MisalignErr, BusErr      one-cycle error pulses
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ValidIn,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic [1:0]  MemSizeIn,
    input  logic        MemSignedIn,
    input  logic [31:0] AddrIn,
    input  logic [31:0] WriteDataIn,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic [31:0] ReadDataOut,
    output logic        Stall,
    output logic        MisalignErr,
    output logic        BusErr
);

    // Counter wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
    localparam int              c_CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT - 1);

    localparam logic [1:0] c_SZ_WORD = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          r_state,  w_state_nxt;
    logic            r_req,    w_req_nxt;
    logic            r_we,     w_we_nxt;
    logic [31:0]     r_addr,   w_addr_nxt;
    logic [3:0]      r_be,     w_be_nxt;
    logic [31:0]     r_wdata,  w_wdata_nxt;
    logic [31:0]     r_rdata,  w_rdata_nxt;
    logic            r_mis,    w_mis_nxt;
    logic            r_buserr, w_buserr_nxt;
    logic [c_CW-1:0] r_cnt,    w_cnt_nxt;

    // Shape of the outstanding load, captured at request time so the
    // extraction does not depend on upstream holding its inputs past REQ.
    logic            r_is_load, w_is_load_nxt;
    logic [1:0]      r_size,    w_size_nxt;
    logic            r_signed,  w_signed_nxt;
    logic [1:0]      r_off,     w_off_nxt;

    // ------------------------------------------------------------------
    // Decode of the incoming operation
    // ------------------------------------------------------------------
    logic        w_op;
    logic        w_misalign;
    logic [3:0]  w_be_lane;
    logic [31:0] w_wdata_lane;

    assign w_op = ValidIn & (MemReadIn | MemWriteIn);

    always_comb begin
        w_misalign = 1'b0;
        case (MemSizeIn)
            c_SZ_WORD: w_misalign = (AddrIn[1:0] != 2'b00);
            c_SZ_HALF: w_misalign = AddrIn[0];
            c_SZ_BYTE: w_misalign = 1'b0;
            default:   w_misalign = 1'b1;
        endcase
    end

    // Byte enables apply to loads as well as stores; store data is
    // replicated across lanes so memory can pick whichever lane is enabled.
    always_comb begin
        w_be_lane    = 4'b1111;
        w_wdata_lane = WriteDataIn;
        case (MemSizeIn)
            c_SZ_HALF: begin
                w_be_lane    = AddrIn[1] ? 4'b1100 : 4'b0011;
                w_wdata_lane = {2{WriteDataIn[15:0]}};
            end
            c_SZ_BYTE: begin
                w_be_lane    = 4'b0001 << AddrIn[1:0];
                w_wdata_lane = {4{WriteDataIn[7:0]}};
            end
            default: begin
                w_be_lane    = 4'b1111;
                w_wdata_lane = WriteDataIn;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_ext;

    always_comb begin
        w_ld_byte = MemRData[7:0];
        case (r_off)
            2'd0:    w_ld_byte = MemRData[7:0];
            2'd1:    w_ld_byte = MemRData[15:8];
            2'd2:    w_ld_byte = MemRData[23:16];
            default: w_ld_byte = MemRData[31:24];
        endcase
    end

    assign w_ld_half = r_off[1] ? MemRData[31:16] : MemRData[15:0];

    always_comb begin
        w_ld_ext = MemRData;
        case (r_size)
            c_SZ_HALF: w_ld_ext = {{16{r_signed & w_ld_half[15]}}, w_ld_half};
            c_SZ_BYTE: w_ld_ext = {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};
            default:   w_ld_ext = MemRData;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_we_nxt      = r_we;
        w_addr_nxt    = r_addr;
        w_be_nxt      = r_be;
        w_wdata_nxt   = r_wdata;
        w_rdata_nxt   = r_rdata;
        w_mis_nxt     = 1'b0;
        w_buserr_nxt  = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_is_load_nxt = r_is_load;
        w_size_nxt    = r_size;
        w_signed_nxt  = r_signed;
        w_off_nxt     = r_off;

        case (r_state)
            ST_IDLE: begin
                w_req_nxt = 1'b0;
                w_cnt_nxt = '0;
                if (w_op) begin
                    if (w_misalign) begin
                        // Rejected without touching the bus; the pipeline
                        // moves on and the error pulse follows next cycle.
                        w_mis_nxt   = 1'b1;
                        w_rdata_nxt = '0;
                    end else begin
                        w_state_nxt   = ST_REQ;
                        w_req_nxt     = 1'b1;
                        // Store takes priority when both controls are set.
                        w_we_nxt      = MemWriteIn;
                        w_addr_nxt    = {AddrIn[31:2], 2'b00};
                        w_be_nxt      = w_be_lane;
                        w_wdata_nxt   = w_wdata_lane;
                        w_is_load_nxt = ~MemWriteIn;
                        w_size_nxt    = MemSizeIn;
                        w_signed_nxt  = MemSignedIn;
                        w_off_nxt     = AddrIn[1:0];
                    end
                end
            end

            ST_REQ: begin
                if (MemAck) begin
                    w_state_nxt = ST_DONE;
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    if (r_is_load) begin
                        w_rdata_nxt = w_ld_ext;
                    end
                end else if (r_cnt == c_TO_LAST) begin
                    // The final allowed REQ cycle passed with no ack.
                    w_state_nxt  = ST_DONE;
                    w_req_nxt    = 1'b0;
                    w_buserr_nxt = 1'b1;
                    w_rdata_nxt  = '0;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end

            ST_DONE: begin
                // Stall is low here so the pipeline advances; the op still
                // visible on the inputs has been serviced and is ignored.
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
                w_cnt_nxt   = '0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_mis     <= 1'b0;
            r_buserr  <= 1'b0;
            r_cnt     <= '0;
            r_is_load <= 1'b0;
            r_size    <= '0;
            r_signed  <= 1'b0;
            r_off     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_we      <= w_we_nxt;
            r_addr    <= w_addr_nxt;
            r_be      <= w_be_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rdata   <= w_rdata_nxt;
            r_mis     <= w_mis_nxt;
            r_buserr  <= w_buserr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_is_load <= w_is_load_nxt;
            r_size    <= w_size_nxt;
            r_signed  <= w_signed_nxt;
            r_off     <= w_off_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Stall drops in DONE so MEM/WB captures ReadDataOut at the end of it.
    assign Stall       = w_op & ~w_misalign & (r_state != ST_DONE);

    assign MemReq      = r_req;
    assign MemWe       = r_we;
    assign MemAddr     = r_addr;
    assign MemBe       = r_be;
    assign MemWData    = r_wdata;
    assign ReadDataOut = r_rdata;
    assign MisalignErr = r_mis;
    assign BusErr      = r_buserr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. A driver issues
//               directed operations and pushes the hand-computed response
//               into a queue; a monitor pops and compares whenever the DUT
//               raises a request, completes one, or flags a misalignment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        ValidIn, MemReadIn, MemWriteIn, MemSignedIn, MemAck;
    logic [1:0]  MemSizeIn;
    logic [31:0] AddrIn, WriteDataIn, MemRData;
    logic        MemReq, MemWe, Stall, MisalignErr, BusErr;
    logic [31:0] MemAddr, MemWData, ReadDataOut;
    logic [3:0]  MemBe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          mis;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          chk_wd;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] rdata;
        bit          buserr;
    } exp_t;

    exp_t q[$];

    mem_access_stage #(.TIMEOUT(16)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .ValidIn     (ValidIn),
        .MemReadIn   (MemReadIn),
        .MemWriteIn  (MemWriteIn),
        .MemSizeIn   (MemSizeIn),
        .MemSignedIn (MemSignedIn),
        .AddrIn      (AddrIn),
        .WriteDataIn (WriteDataIn),
        .MemReq      (MemReq),
        .MemWe       (MemWe),
        .MemAddr     (MemAddr),
        .MemBe       (MemBe),
        .MemWData    (MemWData),
        .MemRData    (MemRData),
        .MemAck      (MemAck),
        .ReadDataOut (ReadDataOut),
        .Stall       (Stall),
        .MisalignErr (MisalignErr),
        .BusErr      (BusErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit mis, input bit we, input logic [31:0] addr,
                                input logic [3:0] be, input bit chk_wd, input logic [31:0] wdata,
                                input bit chk_rd, input logic [31:0] rdata, input bit buserr);
        exp_t e;
        e.mis = mis; e.we = we; e.addr = addr; e.be = be; e.chk_wd = chk_wd;
        e.wdata = wdata; e.chk_rd = chk_rd; e.rdata = rdata; e.buserr = buserr;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge Clk);
            if (MisalignErr) begin
                if (q.size() == 0) begin
                    chk("unexpected_misalign", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("misalign_expected", 32'(MisalignErr), 32'(e.mis));
                    chk("misalign_rdata", ReadDataOut, 32'h0);
                    chk("misalign_noreq", 32'(MemReq), 32'd0);
                end
            end
            if (MemReq && !prev_req) begin
                if (q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    e = q[0];
                    chk("req_on_misaligned", 32'(e.mis), 32'd0);
                    chk("req_we", 32'(MemWe), 32'(e.we));
                    chk("req_addr", MemAddr, e.addr);
                    chk("req_be", 32'(MemBe), 32'(e.be));
                    if (e.chk_wd) chk("req_wdata", MemWData, e.wdata);
                end
            end
            if (!MemReq && prev_req) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_buserr", 32'(BusErr), 32'(e.buserr));
                    if (e.chk_rd) chk("done_rdata", ReadDataOut, e.rdata);
                end
            end
            prev_req = MemReq;
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic idle_inputs();
        ValidIn = 0; MemReadIn = 0; MemWriteIn = 0; MemSizeIn = 2'b00;
        MemSignedIn = 0; AddrIn = '0; WriteDataIn = '0;
    endtask

    // waits < 0 means memory never acknowledges.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                          input int waits, input exp_t e);
        int n;
        q.push_back(e);
        @(posedge Clk); #1;
        ValidIn = 1; MemReadIn = rd; MemWriteIn = wr; MemSizeIn = sz;
        MemSignedIn = sg; AddrIn = addr; WriteDataIn = wd;
        #1;
        chk("stall_first_cycle", 32'(Stall), e.mis ? 32'd0 : 32'd1);
        if (e.mis) begin
            @(posedge Clk); #1;
            idle_inputs();
            @(posedge Clk); #1;
            chk("misalign_no_req_after", 32'(MemReq), 32'd0);
            return;
        end
        @(posedge Clk); #1;
        if (waits >= 0) begin
            for (int i = 0; i < waits; i++) begin
                chk("stall_wait", 32'(Stall), 32'd1);
                @(posedge Clk); #1;
            end
            chk("stall_ack_cycle", 32'(Stall), 32'd1);
            MemAck = 1; MemRData = rdat;
            @(posedge Clk); #1;
            MemAck = 0; MemRData = 32'h5A5A5A5A;
        end else begin
            n = 0;
            while (MemReq && n < 40) begin
                @(posedge Clk); #1;
                n++;
            end
            chk("timeout_req_cycles", 32'(n), 32'd16);
        end
        #1;
        chk("stall_done", 32'(Stall), 32'd0);
        @(posedge Clk); #1;
        idle_inputs();
    endtask

    task automatic reset_in_req();
        q.push_back(mk(0, 0, 32'h600, 4'b1111, 0, 0, 1, 32'h0, 0));
        @(posedge Clk); #1;
        ValidIn = 1; MemReadIn = 1; MemSizeIn = 2'b00; AddrIn = 32'h600;
        @(posedge Clk); #1;               // REQ cycle 1
        repeat (2) begin @(posedge Clk); #1; end
        chk("rst_req_held", 32'(MemReq), 32'd1);
        Rst = 1;                          // REQ cycle 3
        @(posedge Clk); #1;
        Rst = 0;
        idle_inputs();
        chk("rst_req_dropped", 32'(MemReq), 32'd0);
        chk("rst_no_buserr", 32'(BusErr), 32'd0);
        MemAck = 1; MemRData = 32'h11111111;
        #1;
        chk("rst_stall_low", 32'(Stall), 32'd0);
        @(posedge Clk); #1;
        MemAck = 0;
        chk("late_ack_noreq", 32'(MemReq), 32'd0);
        chk("late_ack_rdata", ReadDataOut, 32'h0);
        chk("late_ack_nobuserr", 32'(BusErr), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        Rst = 1; MemAck = 0; MemRData = '0;
        idle_inputs();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_memwe", 32'(MemWe), 32'd0);
        chk("rst_membe", 32'(MemBe), 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_memwdata", MemWData, 32'd0);
        chk("rst_rdata", ReadDataOut, 32'd0);
        chk("rst_misalign", 32'(MisalignErr), 32'd0);
        chk("rst_buserr", 32'(BusErr), 32'd0);
        Rst = 0;

        // LW 0x100, immediate ack
        run_op(1, 0, 2'b00, 0, 32'h100, 0, 32'hDEADBEEF, 0,
               mk(0, 0, 32'h100, 4'b1111, 0, 0, 1, 32'hDEADBEEF, 0));
        // LB signed at 0x103
        run_op(1, 0, 2'b10, 1, 32'h103, 0, 32'h80112233, 1,
               mk(0, 0, 32'h100, 4'b1000, 0, 0, 1, 32'hFFFFFF80, 0));
        // LBU at 0x103
        run_op(1, 0, 2'b10, 0, 32'h103, 0, 32'h80112233, 2,
               mk(0, 0, 32'h100, 4'b1000, 0, 0, 1, 32'h00000080, 0));
        // LW at 0x101: misaligned, clears ReadDataOut
        run_op(1, 0, 2'b00, 0, 32'h101, 0, 0, 0,
               mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        // SH 0x102
        run_op(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 0, 0,
               mk(0, 1, 32'h100, 4'b1100, 1, 32'hABCDABCD, 0, 0, 0));
        // LH signed upper half
        run_op(1, 0, 2'b01, 1, 32'h102, 0, 32'h80017FFF, 0,
               mk(0, 0, 32'h100, 4'b1100, 0, 0, 1, 32'hFFFF8001, 0));
        // LHU lower half
        run_op(1, 0, 2'b01, 0, 32'h100, 0, 32'h1234F00D, 1,
               mk(0, 0, 32'h100, 4'b0011, 0, 0, 1, 32'h0000F00D, 0));
        // LH signed lower half
        run_op(1, 0, 2'b01, 1, 32'h100, 0, 32'h1234F00D, 0,
               mk(0, 0, 32'h100, 4'b0011, 0, 0, 1, 32'hFFFFF00D, 0));
        // LB signed, positive byte at offset 1
        run_op(1, 0, 2'b10, 1, 32'h205, 0, 32'h00007F00, 0,
               mk(0, 0, 32'h204, 4'b0010, 0, 0, 1, 32'h0000007F, 0));
        // SB 0x201
        run_op(0, 1, 2'b10, 0, 32'h201, 32'h123456A5, 0, 0,
               mk(0, 1, 32'h200, 4'b0010, 1, 32'hA5A5A5A5, 0, 0, 0));
        // SW 0x300
        run_op(0, 1, 2'b00, 0, 32'h300, 32'hCAFEF00D, 0, 1,
               mk(0, 1, 32'h300, 4'b1111, 1, 32'hCAFEF00D, 0, 0, 0));
        // Read and write both set: store wins
        run_op(1, 1, 2'b00, 0, 32'h400, 32'h01020304, 0, 0,
               mk(0, 1, 32'h400, 4'b1111, 1, 32'h01020304, 0, 0, 0));
        // LH at 0x103 and reserved size: misaligned
        run_op(1, 0, 2'b01, 1, 32'h103, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        run_op(1, 0, 2'b11, 0, 32'h100, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        // Reload a nonzero value, then reset mid-request
        run_op(1, 0, 2'b00, 0, 32'h104, 0, 32'h13572468, 0,
               mk(0, 0, 32'h104, 4'b1111, 0, 0, 1, 32'h13572468, 0));
        reset_in_req();
        // Reload, then a load that never acks
        run_op(1, 0, 2'b00, 0, 32'h108, 0, 32'h89ABCDEF, 0,
               mk(0, 0, 32'h108, 4'b1111, 0, 0, 1, 32'h89ABCDEF, 0));
        run_op(1, 0, 2'b00, 0, 32'h500, 0, 0, -1,
               mk(0, 0, 32'h500, 4'b1111, 0, 0, 1, 32'h0, 1));
        @(posedge Clk); #1;
        chk("post_timeout_buserr_cleared", 32'(BusErr), 32'd0);
        chk("post_timeout_noreq", 32'(MemReq), 32'd0);

        repeat (3) @(posedge Clk);
        #1;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
